// File: rtl/int_seq_pkg.sv
// Shared encodings, constants and the output decode for the 6502 interrupt sequencer.
package int_seq_pkg;

  localparam int unsigned STEP_W = 3;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned VEC_W  = 16;

  typedef enum logic [KIND_W-1:0] {
    KIND_RESET = 2'd0,
    KIND_NMI   = 2'd1,
    KIND_IRQ   = 2'd2,
    KIND_BRK   = 2'd3
  } seq_kind_e;

  typedef enum logic [SEL_W-1:0] {
    PUSH_PCH = 2'd0,
    PUSH_PCL = 2'd1,
    PUSH_P   = 2'd2
  } push_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam logic [VEC_W-1:0] VEC_NMI   = 16'hFFFA;
  localparam logic [VEC_W-1:0] VEC_RESET = 16'hFFFC;
  localparam logic [VEC_W-1:0] VEC_IRQ   = 16'hFFFE;

  localparam logic [STEP_W-1:0] STEP_PUSH_FIRST = 3'd2;
  localparam logic [STEP_W-1:0] STEP_PUSH_MID   = 3'd3;
  localparam logic [STEP_W-1:0] STEP_PUSH_LAST  = 3'd4;
  localparam logic [STEP_W-1:0] STEP_VEC_LO     = 3'd5;
  localparam logic [STEP_W-1:0] STEP_LAST       = 3'd6;

  typedef struct packed {
    logic              active;
    logic [STEP_W-1:0] step;
    seq_kind_e         kind;
    logic              push_en;
    push_sel_e         push_sel;
    logic              b_flag;
    logic              vec_fetch;
    logic [VEC_W-1:0]  vec_addr;
    logic              done;
  } seq_out_t;

  // Strobes and vector address for a given sequencer state.
  function automatic seq_out_t seq_decode(input logic              active,
                                          input logic [STEP_W-1:0] step,
                                          input seq_kind_e         kind,
                                          input logic              nmi_vec);
    seq_out_t         o;
    logic [VEC_W-1:0] base;
    o        = '0;
    base     = nmi_vec ? VEC_NMI : ((kind == KIND_RESET) ? VEC_RESET : VEC_IRQ);
    o.active = active;
    o.step   = step;
    o.kind   = kind;
    case (step)
      STEP_PUSH_FIRST: o.push_sel = PUSH_PCH;
      STEP_PUSH_MID:   o.push_sel = PUSH_PCL;
      STEP_PUSH_LAST:  o.push_sel = PUSH_P;
      default:         o.push_sel = PUSH_PCH;
    endcase
    o.push_en   = active && (kind != KIND_RESET) &&
                  (step >= STEP_PUSH_FIRST) && (step <= STEP_PUSH_LAST);
    o.b_flag    = active && (kind == KIND_BRK);
    o.vec_fetch = active && (step >= STEP_VEC_LO);
    o.vec_addr  = base | VEC_W'(step == STEP_LAST);
    o.done      = active && (step == STEP_LAST);
    return o;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for one asynchronous level, with a configurable reset value.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [DEPTH-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/int_sequencer.sv
// Interrupt arbiter and 7-step 6502 interrupt sequence (pushes, then vector fetch).
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter int unsigned        NUM_IRQ        = 3,
  parameter logic [NUM_IRQ-1:0] IrqBubblesMask = NUM_IRQ'(7),
  parameter int unsigned        SYNC_STAGES    = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               cycle_en_i,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic               nmi_line_i,
  input  logic               irq_mask_i,
  input  logic               sync_i,
  input  logic               brk_op_i,
  output logic               seq_active_o,
  output logic [STEP_W-1:0]  seq_step_o,
  output logic [KIND_W-1:0]  seq_kind_o,
  output logic               push_en_o,
  output logic [SEL_W-1:0]   push_sel_o,
  output logic               b_flag_o,
  output logic               vec_fetch_o,
  output logic [VEC_W-1:0]   vec_addr_o,
  output logic               set_i_o,
  output logic               seq_done_o,
  output logic [NUM_IRQ-1:0] irq_source_o
);

  logic [NUM_IRQ-1:0] irq_sync;
  logic [NUM_IRQ-1:0] irq_active;
  logic               irq_any;
  logic               nmi_sync;

  seq_state_e         state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  seq_kind_e          kind_q, kind_d;
  logic               hijack_q, hijack_d;
  logic               nmi_latch_q, nmi_latch_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic [NUM_IRQ-1:0] irq_src_q, irq_src_d;
  seq_out_t           out_q, out_d;
  logic               nmi_edge;
  logic               accept;

  // Synchronisers idle at the inactive level of each line.
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq_sync
    sync_ff #(
      .STAGES   (SYNC_STAGES),
      .RESET_VAL(IrqBubblesMask[i])
    ) u_sync (
      .clk_i(clock_i),
      .rst_i(reset_i),
      .d_i  (irq_lines_i[i]),
      .q_o  (irq_sync[i])
    );
  end

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_nmi_sync (
    .clk_i(clock_i),
    .rst_i(reset_i),
    .d_i  (nmi_line_i),
    .q_o  (nmi_sync)
  );

  assign irq_active = irq_sync ^ IrqBubblesMask;
  assign irq_any    = |irq_active;

  // Next-state: NMI edge latch, boundary arbitration and step sequencing.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    kind_d      = kind_q;
    hijack_d    = hijack_q;
    nmi_latch_d = nmi_latch_q;
    nmi_prev_d  = nmi_prev_q;
    irq_src_d   = irq_src_q;
    accept      = 1'b0;
    nmi_edge    = cycle_en_i && nmi_prev_q && !nmi_sync;

    if (cycle_en_i) begin
      nmi_prev_d = nmi_sync;
    end
    if (nmi_edge) begin
      nmi_latch_d = 1'b1;
    end

    if (cycle_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (sync_i) begin
            if (nmi_latch_q) begin
              accept = 1'b1;
              kind_d = KIND_NMI;
            end else if (irq_any && !irq_mask_i) begin
              accept    = 1'b1;
              kind_d    = KIND_IRQ;
              irq_src_d = irq_active;
            end else if (brk_op_i) begin
              accept = 1'b1;
              kind_d = KIND_BRK;
            end
          end
          if (accept) begin
            state_d  = ST_RUN;
            step_d   = '0;
            hijack_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (step_q == STEP_LAST) begin
            state_d = ST_IDLE;
            step_d  = '0;
          end else begin
            step_d = step_q + 3'd1;
            // Leaving the last push cycle: commit the vector base and consume the NMI.
            if (step_q == STEP_PUSH_LAST) begin
              if ((kind_q == KIND_IRQ || kind_q == KIND_BRK) && nmi_latch_d) begin
                hijack_d = 1'b1;
              end
              if (kind_q == KIND_NMI || hijack_d) begin
                nmi_latch_d = 1'b0;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    out_d = seq_decode(state_d == ST_RUN, step_d, kind_d,
                       (kind_d == KIND_NMI) || hijack_d);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      step_q      <= '0;
      kind_q      <= KIND_RESET;
      hijack_q    <= 1'b0;
      nmi_latch_q <= 1'b0;
      nmi_prev_q  <= 1'b1;
      irq_src_q   <= '0;
      out_q       <= seq_decode(1'b1, '0, KIND_RESET, 1'b0);
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      kind_q      <= kind_d;
      hijack_q    <= hijack_d;
      nmi_latch_q <= nmi_latch_d;
      nmi_prev_q  <= nmi_prev_d;
      irq_src_q   <= irq_src_d;
      out_q       <= out_d;
    end
  end

  assign seq_active_o = out_q.active;
  assign seq_step_o   = out_q.step;
  assign seq_kind_o   = out_q.kind;
  assign push_en_o    = out_q.push_en;
  assign push_sel_o   = out_q.push_sel;
  assign b_flag_o     = out_q.b_flag;
  assign vec_fetch_o  = out_q.vec_fetch;
  assign vec_addr_o   = out_q.vec_addr;
  assign set_i_o      = out_q.done;
  assign seq_done_o   = out_q.done;
  assign irq_source_o = irq_src_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_int_sequencer;

  localparam int unsigned NUM_IRQ = 3;
  localparam logic [2:0]  MASK    = 3'b111;
  localparam int unsigned STAGES  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic [2:0]  irq = 3'b111;
  logic        nmi = 1'b1;
  logic        imask = 1'b0;
  logic        sync = 1'b0;
  logic        brk = 1'b0;

  logic        s_active;
  logic [2:0]  s_step;
  logic [1:0]  s_kind;
  logic        push_en;
  logic [1:0]  push_sel;
  logic        b_flag;
  logic        vec_fetch;
  logic [15:0] vec_addr;
  logic        set_i;
  logic        seq_done;
  logic [2:0]  irq_src;

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;
  int cen_mode = 0;
  int cen_cnt  = 0;

  int_sequencer #(
    .NUM_IRQ       (NUM_IRQ),
    .IrqBubblesMask(MASK),
    .SYNC_STAGES   (STAGES)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .cycle_en_i  (cen),
    .irq_lines_i (irq),
    .nmi_line_i  (nmi),
    .irq_mask_i  (imask),
    .sync_i      (sync),
    .brk_op_i    (brk),
    .seq_active_o(s_active),
    .seq_step_o  (s_step),
    .seq_kind_o  (s_kind),
    .push_en_o   (push_en),
    .push_sel_o  (push_sel),
    .b_flag_o    (b_flag),
    .vec_fetch_o (vec_fetch),
    .vec_addr_o  (vec_addr),
    .set_i_o     (set_i),
    .seq_done_o  (seq_done),
    .irq_source_o(irq_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $display("FAIL timeout %s: awaited condition not seen within 200 cycles", tag);
  endtask

  // Cycle_En pattern generator.
  always @(negedge clk) begin
    cen_cnt++;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = (cen_cnt % 2 == 0);
      2:       cen = (cen_cnt % 3 == 0);
      default: cen = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- behavioural model ----------------
  bit         m_active;
  int         m_step;
  int         m_kind;   // 0 RESET, 1 NMI, 2 IRQ, 3 BRK
  bit         m_latch;
  bit         m_prev;
  bit         m_fffa;
  logic [2:0] m_src;
  logic       nmi_hist[$];
  logic [2:0] irq_hist[$];

  task automatic model_reset();
    m_active = 1'b1;
    m_step   = 0;
    m_kind   = 0;
    m_latch  = 1'b0;
    m_prev   = 1'b1;
    m_fffa   = 1'b0;
    m_src    = '0;
    nmi_hist = {};
    irq_hist = {};
    for (int i = 0; i < int'(STAGES); i++) begin
      nmi_hist.push_back(1'b1);
      irq_hist.push_back(MASK);
    end
  endtask

  task automatic model_start(input int kind);
    m_active = 1'b1;
    m_step   = 0;
    m_kind   = kind;
    m_fffa   = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin : upd
      logic       ns;
      logic [2:0] isv;
      logic [2:0] act;
      bit         latch_at_boundary;
      ns  = nmi_hist.pop_front();
      nmi_hist.push_back(nmi);
      isv = irq_hist.pop_front();
      irq_hist.push_back(irq);
      act = isv ^ MASK;
      if (cen) begin
        latch_at_boundary = m_latch;
        if (m_prev && !ns) m_latch = 1'b1;
        m_prev = ns;
        if (!m_active) begin
          if (sync) begin
            if (latch_at_boundary) model_start(1);
            else if ((act != 3'b000) && !imask) begin
              model_start(2);
              m_src = act;
            end else if (brk) model_start(3);
          end
        end else if (m_step == 6) begin
          m_active = 1'b0;
          m_step   = 0;
        end else begin
          m_step++;
          if (m_step == 5) begin
            if (m_kind >= 2 && m_latch) m_fffa = 1'b1;
            if (m_kind == 1 || m_fffa) m_latch = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (mon_on) begin : cmp
      bit          e_push;
      bit          e_fetch;
      bit          e_done;
      logic [15:0] e_base;
      int          e_sel;
      e_push  = m_active && m_kind != 0 && m_step >= 2 && m_step <= 4;
      e_fetch = m_active && m_step >= 5;
      e_done  = m_active && m_step == 6;
      e_sel   = (m_step >= 2 && m_step <= 4) ? m_step - 2 : 0;
      e_base  = (m_kind == 1 || m_fffa) ? 16'hFFFA : (m_kind == 0 ? 16'hFFFC : 16'hFFFE);
      chk("m_active", 32'(s_active), 32'(m_active));
      chk("m_step", 32'(s_step), 32'(m_step));
      chk("m_push_en", 32'(push_en), 32'(e_push));
      chk("m_vec_fetch", 32'(vec_fetch), 32'(e_fetch));
      chk("m_set_i", 32'(set_i), 32'(e_done));
      chk("m_seq_done", 32'(seq_done), 32'(e_done));
      chk("m_irq_source", 32'(irq_src), 32'(m_src));
      if (m_active) begin
        chk("m_kind", 32'(s_kind), 32'(m_kind));
        chk("m_push_sel", 32'(push_sel), 32'(e_sel));
        chk("m_b_flag", 32'(b_flag), 32'(m_kind == 3));
      end
      if (e_fetch) begin
        chk("m_vec_addr", 32'(vec_addr), 32'(e_base + 16'(m_step == 6)));
      end
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_step(input int s, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_active && int'(s_step) == s) && n < 200);
    if (!(s_active && int'(s_step) == s)) timeout_fail(tag);
  endtask

  task automatic wait_active(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_active && n < 200);
    if (!s_active) timeout_fail(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_active && n < 200);
    if (s_active) timeout_fail(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #1 rst = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_active", 32'(s_active), 32'd1);
    chk("rst_kind", 32'(s_kind), 32'd0);
    chk("rst_step", 32'(s_step), 32'd0);
    chk("rst_vec", 32'(vec_addr), 32'hFFFC);
    chk("rst_strobes", 32'({push_en, vec_fetch, set_i, seq_done}), 32'd0);
    chk("rst_irq_src", 32'(irq_src), 32'd0);
    rst = 1'b0;

    // RESET sequence after release.
    wait_step(5, "reset_step5");
    chk("reset_vec_lo", 32'(vec_addr), 32'hFFFC);
    @(negedge clk);
    chk("reset_vec_hi", 32'(vec_addr), 32'hFFFD);
    chk("reset_done", 32'(seq_done), 32'd1);
    @(negedge clk);
    chk("reset_idle", 32'(s_active), 32'd0);

    // IRQ on line 0 (active-low).
    irq  = 3'b110;
    sync = 1'b1;
    wait_active("irq_accept");
    chk("irq_kind", 32'(s_kind), 32'd2);
    chk("irq_source", 32'(irq_src), 32'b001);
    irq = 3'b111;
    wait_step(2, "irq_step2");
    chk("irq_push2", 32'({push_en, push_sel, b_flag}), 32'b1_00_0);
    @(negedge clk);
    chk("irq_push3", 32'({push_en, push_sel}), 32'b1_01);
    @(negedge clk);
    chk("irq_push4", 32'({push_en, push_sel}), 32'b1_10);
    wait_step(5, "irq_step5");
    chk("irq_vec_lo", 32'(vec_addr), 32'hFFFE);
    @(negedge clk);
    chk("irq_vec_hi", 32'(vec_addr), 32'hFFFF);
    chk("irq_set_i", 32'(set_i), 32'd1);
    wait_idle("irq_end");
    sync = 1'b0;

    // Masked IRQ is never accepted.
    irq   = 3'b110;
    imask = 1'b1;
    sync  = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("masked_idle", 32'(s_active), 32'd0);
    end
    irq = 3'b111;
    repeat (4) @(negedge clk);
    imask = 1'b0;
    sync  = 1'b0;

    // BRK hijacked by an NMI arriving during the push cycles.
    cen_mode = 1;
    @(negedge clk);
    sync = 1'b1;
    brk  = 1'b1;
    wait_active("brk_accept");
    sync = 1'b0;
    brk  = 1'b0;
    chk("brk_kind", 32'(s_kind), 32'd3);
    wait_step(3, "brk_step3");
    nmi = 1'b0;
    wait_step(5, "brk_step5");
    chk("brk_hijack_vec", 32'(vec_addr), 32'hFFFA);
    chk("brk_kind_kept", 32'(s_kind), 32'd3);
    chk("brk_bflag", 32'(b_flag), 32'd1);
    nmi = 1'b1;
    wait_idle("brk_end");
    sync = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("nmi_latch_cleared", 32'(s_active), 32'd0);
    end
    sync     = 1'b0;
    cen_mode = 0;

    // Two NMI edges before a boundary merge into one sequence.
    repeat (4) @(negedge clk);
    nmi = 1'b0; repeat (4) @(negedge clk);
    nmi = 1'b1; repeat (4) @(negedge clk);
    nmi = 1'b0; repeat (4) @(negedge clk);
    nmi = 1'b1; repeat (4) @(negedge clk);
    sync = 1'b1;
    wait_active("nmi_accept");
    chk("nmi_kind", 32'(s_kind), 32'd1);
    wait_idle("nmi_end");
    repeat (10) begin
      @(negedge clk);
      chk("nmi_once", 32'(s_active), 32'd0);
    end

    // Edge landing in the final step is kept for the next boundary.
    nmi = 1'b0;
    wait_active("nmi2_accept");
    chk("nmi2_kind", 32'(s_kind), 32'd1);
    nmi = 1'b1;
    wait_step(4, "nmi2_step4");
    nmi = 1'b0;
    wait_idle("nmi2_end");
    nmi = 1'b1;
    wait_active("nmi_retained");
    chk("nmi3_kind", 32'(s_kind), 32'd1);
    sync = 1'b0;
    wait_idle("nmi3_end");

    // Sparse Cycle_En during IRQ, then asynchronous reset mid-sequence.
    cen_mode = 2;
    irq  = 3'b101;
    sync = 1'b1;
    wait_active("slow_accept");
    irq  = 3'b111;
    sync = 1'b0;
    chk("slow_source", 32'(irq_src), 32'b010);
    n = 0;
    while (!(s_active && s_step == 3'd4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("slow_span", 32'(n), 32'd12);
    #2 rst = 1'b1;
    #1;
    chk("async_active", 32'(s_active), 32'd1);
    chk("async_step", 32'(s_step), 32'd0);
    chk("async_kind", 32'(s_kind), 32'd0);
    chk("async_vec", 32'(vec_addr), 32'hFFFC);
    chk("async_push", 32'(push_en), 32'd0);
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    cen_mode = 0;
    wait_idle("post_async_reset");

    // Randomized traffic.
    cen_mode = 3;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) irq = 3'($urandom);
      if ($urandom_range(0, 15) == 0) imask = ~imask;
      if ($urandom_range(0, 9) == 0) nmi = ~nmi;
      sync = ($urandom_range(0, 2) == 0);
      brk  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Consumer end of the wired-OR interrupt request lines that our gate library combines (per-input bubble inversion, then OR).
- Synchronises the IRQ request lines and the active-low NMI line, and arbitrates RESET/NMI/IRQ/BRK.
- Runs the 7-cycle 6502 interrupt sequence: stack pushes, then vector fetch.
- Sits beside the CPU core's sequencer and is advanced by the per-CPU-cycle enable.

Parameters:
- NUM_IRQ, 3, number of IRQ request lines.
- IrqBubblesMask, 7, bit i = 1 means Irq_Lines[i] is active-low (inverted before use).
- SYNC_STAGES, 2, synchroniser depth for Irq_Lines and Nmi_Line (minimum 2).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Cycle_En  in  1  one-clock qualifier marking a CPU cycle. All state advances only when it is high.
- Irq_Lines  in  NUM_IRQ  level-sensitive IRQ requests; polarity per IrqBubblesMask.
- Nmi_Line  in  1  active-low, falling-edge-triggered NMI.
- Irq_Mask  in  1  CPU P.I flag; 1 blocks IRQ.
- Sync  in  1  core is at an opcode-fetch boundary.
- Brk_Op  in  1  core decoded BRK; valid only together with Sync.
- Seq_Active  out  1  sequence in progress.
- Seq_Step  out  3  current step, 0..6.
- Seq_Kind  out  2  0=RESET, 1=NMI, 2=IRQ, 3=BRK.
- Push_En  out  1  stack write strobe.
- Push_Sel  out  2  0=PCH, 1=PCL, 2=P.
- B_Flag  out  1  B bit for the pushed P.
- Vec_Fetch  out  1  vector read cycle.
- Vec_Addr  out  16  vector byte address.
- Set_I  out  1  one-cycle pulse: set P.I.
- Seq_Done  out  1  one-cycle pulse: sequence finished.
- Irq_Source  out  NUM_IRQ  snapshot of active IRQ sources at IRQ accept.

Behaviour:
- Reset is asynchronous and active-high. Values while Reset is asserted:
  - Seq_Active=1, Seq_Kind=RESET, Seq_Step=0, Vec_Addr=16'hFFFC.
  - Push_En=0, Vec_Fetch=0, Set_I=0, Seq_Done=0, Irq_Source=0.
  - NMI latch=0.
  - NMI synchroniser flops reset to 1; IRQ synchroniser flops reset to the inactive level.
- On reset release the RESET sequence runs from step 0.
- A Reset assertion mid-sequence aborts immediately and restarts as RESET.
- Synchronisers clock every Clock edge; they are not gated by Cycle_En.
- IRQ request: irq_any = OR over i of (sync(Irq_Lines[i]) XOR IrqBubblesMask[i]).
- NMI edge: detected on a Cycle_En sample where the synchronised value is 0 and the previous Cycle_En sample was 1. The edge sets the NMI latch.
  - An edge arriving while the latch is already set merges; it is not counted twice.
- Idle state: Seq_Active=0. Accept on Cycle_En && Sync with priority NMI latch > (irq_any && !Irq_Mask) > Brk_Op.
  - Accept sets Seq_Active=1 and Seq_Step=0 on the next clock.
  - On IRQ accept, Irq_Source latches the active vector.
  - Sync is ignored while Seq_Active=1.
- Steps 0..6 advance by one per Cycle_En. With Cycle_En low, all non-synchroniser state freezes.
- Steps 0-1: internal cycles, no strobes.
- Steps 2, 3, 4: Push_En=1 with Push_Sel=0, 1, 2 respectively. Push_En is forced to 0 for RESET, but Push_Sel still sequences.
- B_Flag=1 only for BRK.
- Steps 5 and 6: Vec_Fetch=1, Vec_Addr = base at step 5 and base+1 at step 6.
  - Base is FFFA for NMI, FFFC for RESET, FFFE for IRQ/BRK.
- NMI hijack: if Seq_Kind is IRQ or BRK and the NMI latch is set by the end of step 4, steps 5-6 use base FFFA.
  - Seq_Kind and B_Flag are unchanged.
- NMI latch clear: at step 5 of any sequence using base FFFA. An edge detected during step 5 or 6 is retained for the next boundary.
- Step 6 with Cycle_En: Set_I=1 and Seq_Done=1 for that cycle; next clock returns to Idle.
- All outputs are decoded from registered state. There are no combinational paths from input to output.

Decomposition:
- Package int_seq_pkg holds:
  - Seq_Kind encodings.
  - Push_Sel encodings.
  - Vector base constants FFFA, FFFC, FFFE.
  - Step constants: PUSH_FIRST=2, VEC_LO=5, LAST=6.
- One sub-module: sync_ff, a SYNC_STAGES-deep synchroniser with a reset-value parameter. It is instanced per IRQ line and once for NMI.

Test Plan:
- Reset held 3 clocks, then released with Cycle_En=1 every clock:
  - Push_En stays 0 throughout.
  - Vec_Addr = FFFC at step 5 and FFFD at step 6.
  - Seq_Done pulses at step 6.
  - Seq_Active=0 on the following clock.
- Irq_Lines=3'b110 (mask 7, so line 0 active), Irq_Mask=0, Sync=1:
  - Seq_Kind=IRQ and Irq_Source=3'b001.
  - Push steps 2/3/4 with B_Flag=0.
  - Vector FFFE/FFFF.
  - Set_I pulse.
- Same stimulus with Irq_Mask=1: no accept across 20 Sync boundaries; Seq_Active stays 0.
- Brk_Op with Sync, then Nmi_Line falling edge during step 3:
  - Vec_Addr=FFFA at step 5.
  - Seq_Kind stays BRK and B_Flag=1.
  - NMI latch clears.
- Two NMI falling edges before the next Sync: exactly one NMI sequence runs. An edge injected at step 6 produces a second NMI sequence at the next Sync.
- Cycle_En toggling 1-of-3 clocks during an IRQ sequence: the step advances only on enabled clocks. Reset asserted at step 4 forces the RESET state immediately (asynchronously).
